// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and encodings for the ATM transaction controller
// Contents: atm_state_t FSM encoding, tipo_trans encoding, card-type encoding.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIN      = 3'd1,
        ST_AUTH     = 3'd2,
        ST_DEPOSIT  = 3'd3,
        ST_WITHDRAW = 3'd4,
        ST_LOCKED   = 3'd5
    } atm_state_t;

    localparam logic TRANS_DEP = 1'b0;
    localparam logic TRANS_RET = 1'b1;

    localparam logic CARD_HOME    = 1'b0;
    localparam logic CARD_FOREIGN = 1'b1;

endpackage

// File: rtl/atm_pin_entry.sv
// rtl/atm_pin_entry.sv - PIN digit collection, comparison and failed-attempt counting
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           start of a card session: zero digit/try counters and shift reg
//   en              high while the controller is in the PIN state
//   pin             reference PIN, first digit in MSBs
//   digito/_stb     keypad digit and its one-cycle strobe
//   attempt_done    this strobe completes a full PIN attempt (combinational)
//   match           the completed attempt (including this digit) equals pin
//   tries           failed attempts so far in this session (registered)
//   warn            this attempt fails and brings tries to MAX_TRIES-1
//   lock_req        this attempt fails and brings tries to MAX_TRIES
module atm_pin_entry #(
    parameter int PIN_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_TRIES  = 3,
    localparam int PIN_W     = PIN_DIGITS * DIGIT_W,
    localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic [PIN_W-1:0]   pin,
    input  logic [DIGIT_W-1:0] digito,
    input  logic               digito_stb,
    output logic               attempt_done,
    output logic               match,
    output logic [TRY_W-1:0]   tries,
    output logic               warn,
    output logic               lock_req
);

    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    logic [PIN_W-1:0] shift_q;
    logic [PIN_W-1:0] shift_nx;
    logic [CNT_W-1:0] dig_cnt;
    logic [TRY_W-1:0] tries_nx;
    logic             strobe;

    assign strobe   = en & digito_stb;
    // Older digits move toward the MSBs so the first digit typed lines up with pin's MSBs.
    assign shift_nx = (shift_q << DIGIT_W) | PIN_W'(digito);
    assign tries_nx = tries + TRY_W'(1);

    // Compare against the shifted value so the digit arriving now takes part.
    assign attempt_done = strobe && (dig_cnt == CNT_W'(PIN_DIGITS - 1));
    assign match        = (shift_nx == pin);
    assign warn         = attempt_done && !match && (tries_nx == TRY_W'(MAX_TRIES - 1));
    assign lock_req     = attempt_done && !match && (tries_nx == TRY_W'(MAX_TRIES));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            dig_cnt <= '0;
            tries   <= '0;
        end else if (strobe) begin
            shift_q <= shift_nx;
            if (attempt_done) begin
                dig_cnt <= '0;
                tries   <= match ? '0 : tries_nx;
            end else begin
                dig_cnt <= dig_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/atm_controller_p.sv
// rtl/atm_controller_p.sv - ATM transaction controller: card, PIN, deposit/withdrawal
// Optional build macro: ATM_FEE_EN (foreign-card withdrawals cost monto+FEE).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tarjeta_recibida         card present level, sampled in IDLE
//   tarjeta                  1 = home-bank card, 0 = foreign
//   pin                      reference PIN, first digit in MSBs
//   digito/digito_stb        keypad digit and strobe
//   tipo_trans               0 deposit, 1 withdrawal; sampled in AUTH
//   monto/monto_stb          transaction amount and strobe
//   balance                  registered account balance
//   balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto
//                            one-cycle result pulses
//   advertencia, bloqueo     warning level, lock level
//   tipo_de_tarjeta          latched card type: 0 home, 1 foreign
module atm_controller_p
    import atm_pkg::*;
#(
    parameter int                PIN_DIGITS   = 4,
    parameter int                DIGIT_W      = 4,
    parameter int                MAX_TRIES    = 3,
    parameter int                MONTO_W      = 32,
    parameter int                BAL_W        = 64,
    parameter logic [BAL_W-1:0]  INIT_BALANCE = '0,
    parameter logic [BAL_W-1:0]  FEE          = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tarjeta_recibida,
    input  logic                          tarjeta,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] pin,
    input  logic [DIGIT_W-1:0]            digito,
    input  logic                          digito_stb,
    input  logic                          tipo_trans,
    input  logic [MONTO_W-1:0]            monto,
    input  logic                          monto_stb,
    output logic [BAL_W-1:0]              balance,
    output logic                          balance_actualizado,
    output logic                          entregar_dinero,
    output logic                          fondos_insuficientes,
    output logic                          pin_incorrecto,
    output logic                          advertencia,
    output logic                          bloqueo,
    output logic                          tipo_de_tarjeta
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

`ifdef ATM_FEE_EN
    localparam bit FEE_ACTIVE = 1'b1;
`else
    localparam bit FEE_ACTIVE = 1'b0;
`endif

    atm_state_t       state;
    logic             pe_done;
    logic             pe_match;
    logic             pe_warn;
    logic             pe_lock;
    logic [TRY_W-1:0] unused_tries;
    logic [BAL_W-1:0] cost;

    // Counters are held clear for as long as no session is running.
    atm_pin_entry #(
        .PIN_DIGITS (PIN_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .MAX_TRIES  (MAX_TRIES)
    ) u_pin (
        .clk          (clk),
        .rst          (rst),
        .clear        (state == ST_IDLE),
        .en           (state == ST_PIN),
        .pin          (pin),
        .digito       (digito),
        .digito_stb   (digito_stb),
        .attempt_done (pe_done),
        .match        (pe_match),
        .tries        (unused_tries),
        .warn         (pe_warn),
        .lock_req     (pe_lock)
    );

    // Sum is formed at balance width so monto+FEE cannot overflow the check.
    assign cost = BAL_W'(monto)
                + ((FEE_ACTIVE && (tipo_de_tarjeta == CARD_FOREIGN)) ? FEE : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            balance              <= INIT_BALANCE;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            tipo_de_tarjeta      <= 1'b0;
        end else begin
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            pin_incorrecto       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        tipo_de_tarjeta <= tarjeta ? CARD_HOME : CARD_FOREIGN;
                        advertencia     <= 1'b0;
                        state           <= ST_PIN;
                    end
                end
                ST_PIN: begin
                    if (pe_done) begin
                        if (pe_match) begin
                            advertencia <= 1'b0;
                            state       <= ST_AUTH;
                        end else begin
                            pin_incorrecto <= 1'b1;
                            if (pe_lock) begin
                                advertencia <= 1'b0;
                                bloqueo     <= 1'b1;
                                state       <= ST_LOCKED;
                            end else if (pe_warn) begin
                                advertencia <= 1'b1;
                            end
                        end
                    end
                end
                ST_AUTH: begin
                    case (tipo_trans)
                        TRANS_DEP: state <= ST_DEPOSIT;
                        TRANS_RET: state <= ST_WITHDRAW;
                    endcase
                end
                ST_DEPOSIT: begin
                    if (monto_stb) begin
                        balance             <= balance + BAL_W'(monto);
                        balance_actualizado <= 1'b1;
                        state               <= ST_IDLE;
                    end
                end
                ST_WITHDRAW: begin
                    if (monto_stb) begin
                        if (balance >= cost) begin
                            balance             <= balance - cost;
                            balance_actualizado <= 1'b1;
                            entregar_dinero     <= 1'b1;
                        end else begin
                            fondos_insuficientes <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    bloqueo <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
